// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, default read latency and FSM states for the SRAM model.
package sram_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int READ_LAT_DEF = 2;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID, WRITE} sram_state_e;
endpackage

// File: rtl/sram_array.sv
// sram_array: DEPTH x 16 storage with byte-lane synchronous write and combinational read.
module sram_array
  import sram_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [1:0]             be,
  input  logic [AW-1:0]          addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata
);
  logic [SRAM_DATA_W-1:0] mem [DEPTH];
  // Contents survive reset; the reset only blocks stores on edges where it is held.
  always_ff @(posedge clk or negedge rst)
    if (rst && we) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0] <= wdata[7:0];
    end
  assign rdata = mem[addr];
endmodule

// File: rtl/sram_responder.sv
// sram_responder: cycle-based 16-bit SRAM chip model with programmable read latency on a shared DQ bus.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  input  logic                   SRAM_WE_N,
  input  logic                   SRAM_OE_N,
  input  logic                   SRAM_CE_N,
  input  logic                   SRAM_UB_N,
  input  logic                   SRAM_LB_N,
  output logic                   rd_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAT = 3'(READ_LAT);
  sram_state_e state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [SRAM_DATA_W-1:0] out_q, rdata;
  logic [1:0] dq_oe;
  logic load, same;
  sram_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (!SRAM_CE_N && !SRAM_WE_N),
    .be   (~{SRAM_UB_N, SRAM_LB_N}),
    .addr (SRAM_ADDR[AW-1:0]),
    .wdata(SRAM_DQ),
    .rdata(rdata)
  );
  assign same = SRAM_ADDR == addr_q;
  // A read continues only while the same address stays requested; anything else restarts the count.
  always_comb begin
    state_d = IDLE;
    cnt_d = '0;
    load = 1'b0;
    if (!SRAM_CE_N && !SRAM_WE_N) state_d = WRITE;
    else if (!SRAM_CE_N && !SRAM_OE_N) begin
      cnt_d = (state == RD_WAIT && same) ? cnt + 3'd1 : (state == RD_VALID && same) ? LAT : 3'd1;
      load = cnt_d == LAT;
      state_d = load ? RD_VALID : RD_WAIT;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      out_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      addr_q <= SRAM_ADDR;
      if (load) out_q <= rdata;
    end
  assign rd_valid = state == RD_VALID;
  assign dq_oe = (state == RD_WAIT || state == RD_VALID) ? ~{SRAM_UB_N, SRAM_LB_N} : 2'b00;
  assign SRAM_DQ[15:8] = dq_oe[1] ? out_q[15:8] : 8'hzz;
  assign SRAM_DQ[7:0] = dq_oe[0] ? out_q[7:0] : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed and random checks of the SRAM model against a request-age reference model.
module tb_sram_responder;
  localparam int DEPTH = 65536;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [17:0] addr = '0;
  logic ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, ub_n = 1'b1, lb_n = 1'b1;
  logic drv_en = 1'b0;
  logic [15:0] drv_val = '0;
  wire [15:0] dq;
  logic rd_valid;
  int n_tests = 0, n_fail = 0;
  int age = 0;
  logic [17:0] last_a = '0;
  logic [15:0] last_word = '0;
  logic [15:0] mem_m [DEPTH];
  assign dq = drv_en ? drv_val : 16'hzzzz;
  always #5 clk = ~clk;
  sram_responder #(.DEPTH(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .rd_valid(rd_valid)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Reference: a read is valid once the same request has been seen on LAT consecutive edges.
  task automatic step();
    logic [1:0] exp_oe;
    int idx;
    @(posedge clk);
    idx = int'(addr) % DEPTH;
    if (!rst) begin
      age = 0;
      last_word = '0;
    end else if (!ce_n && !we_n) begin
      if (!ub_n) mem_m[idx][15:8] = drv_val[15:8];
      if (!lb_n) mem_m[idx][7:0] = drv_val[7:0];
      age = 0;
    end else if (!ce_n && !oe_n) begin
      age = (age > 0 && addr == last_a) ? age + 1 : 1;
      last_a = addr;
      if (age >= LAT) last_word = mem_m[idx];
    end else age = 0;
    #1;
    exp_oe = age > 0 ? ~{ub_n, lb_n} : 2'b00;
    chk("rd_valid", 32'(rd_valid), 32'(age >= LAT));
    chk("dq_oe", 32'(dut.dq_oe), 32'(exp_oe));
    if (exp_oe[1]) chk("dq_hi", 32'(dq[15:8]), 32'(last_word[15:8]));
    if (exp_oe[0]) chk("dq_lo", 32'(dq[7:0]), 32'(last_word[7:0]));
  endtask
  task automatic idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; drv_en = 1'b0;
    step();
  endtask
  task automatic wr(logic [17:0] a, logic [15:0] d, logic u, logic l, logic o);
    if (age > 0) idle();
    addr = a; ce_n = 1'b0; we_n = 1'b0; oe_n = o; ub_n = u; lb_n = l;
    drv_val = d; drv_en = 1'b1;
    step();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; drv_en = 1'b0;
  endtask
  task automatic rd(logic [17:0] a, logic u, logic l, int n);
    drv_en = 1'b0; addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; ub_n = u; lb_n = l;
    repeat (n) step();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    repeat (2) step();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_oe", 32'(dut.dq_oe), 32'd0);
    rst = 1'b1;
    // full write then read, stale zero before valid
    wr(18'h00010, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    rd(18'h00010, 1'b0, 1'b0, 1);
    chk("beef_stale", 32'(dq), 32'h0000);
    chk("beef_wait", 32'(rd_valid), 32'd0);
    step();
    chk("beef_valid", 32'(rd_valid), 32'd1);
    chk("beef_data", 32'(dq), 32'hBEEF);
    // byte lanes
    wr(18'h00020, 16'h1234, 1'b0, 1'b0, 1'b1);
    wr(18'h00020, 16'hAB00, 1'b0, 1'b1, 1'b1);
    rd(18'h00020, 1'b0, 1'b0, 2);
    chk("lane_data", 32'(dq), 32'hAB34);
    lb_n = 1'b1;
    step();
    chk("lane_lo_z", 32'(dut.dq_oe), 32'b10);
    chk("lane_hi", 32'(dq[15:8]), 32'hAB);
    // address change mid-read
    wr(18'h00001, 16'h1111, 1'b0, 1'b0, 1'b1);
    wr(18'h00002, 16'h2222, 1'b0, 1'b0, 1'b1);
    rd(18'h00001, 1'b0, 1'b0, 1);
    rd(18'h00002, 1'b0, 1'b0, 1);
    chk("chg_wait", 32'(rd_valid), 32'd0);
    step();
    chk("chg_valid", 32'(rd_valid), 32'd1);
    chk("chg_data", 32'(dq), 32'h2222);
    // write priority over output enable
    wr(18'h00003, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    chk("prio_bus", 32'(dq), 32'h5A5A);
    rd(18'h00003, 1'b0, 1'b0, 2);
    chk("prio_data", 32'(dq), 32'h5A5A);
    // address wrap
    wr(18'h10005, 16'hCAFE, 1'b0, 1'b0, 1'b1);
    rd(18'h00005, 1'b0, 1'b0, 2);
    chk("wrap_data", 32'(dq), 32'hCAFE);
    // async reset mid-read, write held under reset stores nothing
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_oe", 32'(dut.dq_oe), 32'd0);
    ce_n = 1'b1; oe_n = 1'b1;
    wr(18'h00005, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    idle();
    rst = 1'b1;
    rd(18'h00005, 1'b0, 1'b0, 2);
    chk("arst_keep", 32'(dq), 32'hCAFE);
    // randomized traffic over an aliased address window
    for (int i = 0; i < 8; i++) wr(18'(i), 16'($urandom), 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      logic [17:0] a;
      a = {2'($urandom_range(0, 3)), 16'($urandom_range(0, 7))};
      case ($urandom_range(0, 3))
        0: wr(a, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        1: rd(a, 1'($urandom), 1'($urandom), $urandom_range(1, 4));
        2: begin
          rd(a, 1'b0, 1'b0, 1);
          rd(a ^ 18'h1, 1'b0, 1'b0, 3);
        end
        default: begin
          drv_en = 1'b0; ce_n = 1'($urandom); oe_n = 1'b1; we_n = 1'b1;
          if (ce_n) oe_n = 1'($urandom);
          step();
        end
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
